// File: rtl/axi_slice_pkg.sv
// Shared definitions for the AXI channel slices: payload width helpers and beat layouts.
// Each slice flattens its channel into one vector, most-significant field first.
package axi_slice_pkg;

  localparam int unsigned RIdWidth   = 4;
  localparam int unsigned RDataWidth = 64;
  localparam int unsigned RUserWidth = 6;

  // R beat width: resp(2) + last(1) + user + data + id
  function automatic int unsigned r_payload_width(input int unsigned id_w,
                                                  input int unsigned data_w,
                                                  input int unsigned user_w);
    return 3 + user_w + data_w + id_w;
  endfunction

  localparam int unsigned RPayloadWidth = r_payload_width(RIdWidth, RDataWidth, RUserWidth);

  typedef struct packed {
    logic [1:0]            resp;
    logic                  last;
    logic [RUserWidth-1:0] user;
    logic [RDataWidth-1:0] data;
    logic [RIdWidth-1:0]   id;
  } r_beat_t;

endpackage

// File: rtl/axi_r_buffer.sv
// AXI4 R-channel register slice: a small circular FIFO that breaks every combinational
// path between the upstream and downstream handshakes.
module axi_r_buffer
  import axi_slice_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned USER_WIDTH   = 6,
  parameter int unsigned BUFFER_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic                  slave_last_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic                  master_last_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  input  logic                  master_ready_i
);

  localparam int unsigned PayloadW = r_payload_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam int unsigned PtrW     = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(BUFFER_DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(BUFFER_DEPTH);

  logic [PayloadW-1:0] mem_q [BUFFER_DEPTH];
  logic [PayloadW-1:0] mem_d [BUFFER_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                push, pop;
  logic [PayloadW-1:0] wr_payload, rd_payload;

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  assign wr_payload = {slave_resp_i, slave_last_i, slave_user_i, slave_data_i, slave_id_i};

  // Both handshake outputs come from count_q only, so no ready/valid path crosses the slice.
  assign slave_ready_o  = (count_q != CntFull);
  assign master_valid_o = (count_q != '0);

  assign push = slave_valid_i & slave_ready_o;
  assign pop  = master_valid_o & master_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_payload;
      wr_ptr_d        = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_payload    = mem_q[rd_ptr_q];
  assign master_id_o   = rd_payload[ID_WIDTH-1:0];
  assign master_data_o = rd_payload[ID_WIDTH +: DATA_WIDTH];
  assign master_user_o = rd_payload[ID_WIDTH + DATA_WIDTH +: USER_WIDTH];
  assign master_last_o = rd_payload[PayloadW-3];
  assign master_resp_o = rd_payload[PayloadW-1 -: 2];

endmodule

// File: tb/tb_axi_r_buffer.sv
// Bench for axi_r_buffer: a DEPTH=2 instance for directed tables and sequences,
// a DEPTH=3 instance for a random-handshake scoreboard run.
module tb_axi_r_buffer;
  import axi_slice_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DEPTH=2 instance signals
  logic        s2_valid = 0, s2_last = 0, s2_ready, m2_valid, m2_last, m2_ready = 0;
  logic [63:0] s2_data = '0, m2_data;
  logic [1:0]  s2_resp = '0, m2_resp;
  logic [3:0]  s2_id = '0, m2_id;
  logic [5:0]  s2_user = '0, m2_user;

  // DEPTH=3 instance signals
  logic        s3_valid = 0, s3_last = 0, s3_ready, m3_valid, m3_last, m3_ready = 0;
  logic [63:0] s3_data = '0, m3_data;
  logic [1:0]  s3_resp = '0, m3_resp;
  logic [3:0]  s3_id = '0, m3_id;
  logic [5:0]  s3_user = '0, m3_user;

  axi_r_buffer #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6), .BUFFER_DEPTH(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
    .slave_valid_i(s2_valid), .slave_data_i(s2_data), .slave_resp_i(s2_resp),
    .slave_last_i(s2_last), .slave_id_i(s2_id), .slave_user_i(s2_user),
    .slave_ready_o(s2_ready), .master_valid_o(m2_valid), .master_data_o(m2_data),
    .master_resp_o(m2_resp), .master_last_o(m2_last), .master_id_o(m2_id),
    .master_user_o(m2_user), .master_ready_i(m2_ready)
  );

  axi_r_buffer #(.ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6), .BUFFER_DEPTH(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b1),
    .slave_valid_i(s3_valid), .slave_data_i(s3_data), .slave_resp_i(s3_resp),
    .slave_last_i(s3_last), .slave_id_i(s3_id), .slave_user_i(s3_user),
    .slave_ready_o(s3_ready), .master_valid_o(m3_valid), .master_data_o(m3_data),
    .master_resp_o(m3_resp), .master_last_o(m3_last), .master_id_o(m3_id),
    .master_user_o(m3_user), .master_ready_i(m3_ready)
  );

  a_stable3: assert property (@(posedge clk) disable iff (!rst_n)
    (m3_valid && !m3_ready) |=> (m3_valid && $stable({m3_resp, m3_last, m3_user, m3_data, m3_id})));
  a_count2: assert property (@(posedge clk) disable iff (!rst_n) u_dut2.count_q <= 2'd2);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m2_valid"}, m2_valid, 1'b0);
    check({tag, "_s2_ready"}, s2_ready, 1'b1);
    check({tag, "_m2_payload"}, {m2_resp, m2_last, m2_user, m2_data, m2_id}, '0);
    check({tag, "_m3_valid"}, m3_valid, 1'b0);
    check({tag, "_s3_ready"}, s3_ready, 1'b1);
    check({tag, "_m3_payload"}, {m3_resp, m3_last, m3_user, m3_data, m3_id}, '0);
  endtask

  task automatic drive2(input logic v, input logic [63:0] d, input logic [3:0] id, input logic r);
    s2_valid = v;
    s2_data  = d;
    s2_id    = id;
    m2_ready = r;
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [3:0]  sid;
    logic        mr;
    logic        exp_sr;
    logic        exp_mv;
    logic [63:0] exp_md;
    logic [3:0]  exp_mid;
  } vec_t;

  vec_t vecs[7];
  r_beat_t sb2[$];
  r_beat_t sb3[$];

  initial begin
    // Fill then drain with a refused third beat; last row shows stale head after draining.
    vecs[0] = '{1'b1, 64'hA, 4'd1, 1'b0, 1'b1, 1'b0, 64'h0, 4'd0};
    vecs[1] = '{1'b1, 64'hB, 4'd2, 1'b0, 1'b1, 1'b1, 64'hA, 4'd1};
    vecs[2] = '{1'b1, 64'hC, 4'd3, 1'b0, 1'b0, 1'b1, 64'hA, 4'd1};
    vecs[3] = '{1'b1, 64'hC, 4'd3, 1'b0, 1'b0, 1'b1, 64'hA, 4'd1};
    vecs[4] = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b0, 1'b1, 64'hA, 4'd1};
    vecs[5] = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 1'b1, 64'hB, 4'd2};
    vecs[6] = '{1'b0, 64'h0, 4'd0, 1'b0, 1'b1, 1'b0, 64'hA, 4'd1};

    #2;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("idle");

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive2(vecs[i].sv, vecs[i].sd, vecs[i].sid, vecs[i].mr);
      #1;
      check($sformatf("vec%0d_s_ready", i), s2_ready, vecs[i].exp_sr);
      check($sformatf("vec%0d_m_valid", i), m2_valid, vecs[i].exp_mv);
      check($sformatf("vec%0d_m_data", i), m2_data, vecs[i].exp_md);
      check($sformatf("vec%0d_m_id", i), m2_id, vecs[i].exp_mid);
    end

    // Full with ready and a pending beat: pop only, then the pending beat goes in.
    @(negedge clk); drive2(1'b1, 64'h11, 4'd4, 1'b0);
    @(negedge clk); drive2(1'b1, 64'h22, 4'd5, 1'b0);
    @(negedge clk); drive2(1'b1, 64'h33, 4'd6, 1'b1); #1;
    check("full_s_ready", s2_ready, 1'b0);
    check("full_m_data", m2_data, 64'h11);
    @(negedge clk); drive2(1'b1, 64'h33, 4'd6, 1'b0); #1;
    check("after_pop_s_ready", s2_ready, 1'b1);
    check("after_pop_m_data", m2_data, 64'h22);
    @(negedge clk); drive2(1'b0, 64'h0, 4'd0, 1'b1); #1;
    check("refill_s_ready", s2_ready, 1'b0);
    check("refill_m_data", m2_data, 64'h22);
    @(negedge clk); #1;
    check("refill_m_data2", m2_data, 64'h33);
    check("refill_m_id2", m2_id, 4'd6);
    @(negedge clk); drive2(1'b0, 64'h0, 4'd0, 1'b0); #1;
    check("drained_m_valid", m2_valid, 1'b0);

    // 16-beat burst with valid and ready held high.
    begin
      int got = 0;
      for (int k = 0; k < 18; k++) begin
        r_beat_t b;
        @(negedge clk);
        s2_valid = (k < 16);
        s2_data  = 64'(k);
        s2_id    = 4'(k);
        s2_last  = (k == 15);
        s2_resp  = 2'(k);
        s2_user  = 6'(k * 3);
        m2_ready = 1'b1;
        #1;
        if (k >= 1 && k <= 16) check($sformatf("burst_valid%0d", k), m2_valid, 1'b1);
        if (m2_valid && m2_ready) begin
          if (sb2.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL burst_underflow: got beat %0h expected none", m2_data);
          end else begin
            b = sb2.pop_front();
            check("burst_beat", {m2_resp, m2_last, m2_user, m2_data, m2_id}, b);
            got++;
          end
        end
        if (s2_valid && s2_ready) begin
          b.resp = s2_resp; b.last = s2_last; b.user = s2_user; b.data = s2_data; b.id = s2_id;
          sb2.push_back(b);
        end
      end
      check("burst_count", got, 16);
      s2_last = 1'b0;
      m2_ready = 1'b0;
    end

    // Reset while holding two beats: they are discarded.
    @(negedge clk); drive2(1'b1, 64'h44, 4'd8, 1'b0);
    @(negedge clk); drive2(1'b1, 64'h55, 4'd9, 1'b0);
    @(negedge clk); drive2(1'b0, 64'h0, 4'd0, 1'b0); #1;
    check("pre_rst_m_data", m2_data, 64'h44);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive2(1'b1, 64'h66, 4'd7, 1'b0); #1;
    check("post_rst_m_valid0", m2_valid, 1'b0);
    @(negedge clk); drive2(1'b0, 64'h0, 4'd0, 1'b1); #1;
    check("post_rst_m_valid1", m2_valid, 1'b1);
    check("post_rst_m_data", m2_data, 64'h66);
    check("post_rst_m_id", m2_id, 4'd7);
    @(negedge clk); drive2(1'b0, 64'h0, 4'd0, 1'b0); #1;
    check("post_rst_empty", m2_valid, 1'b0);

    // DEPTH=3 random handshakes, 1000 beats.
    fork
      begin : drv3
        int sent = 0;
        int cyc = 0;
        logic acc = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (acc) s3_valid = 1'b0;
          if (!s3_valid && $urandom_range(0, 3) != 0) begin
            s3_valid = 1'b1;
            s3_data  = {$urandom, $urandom};
            s3_resp  = 2'($urandom_range(0, 3));
            s3_last  = 1'($urandom_range(0, 1));
            s3_id    = 4'($urandom_range(0, 15));
            s3_user  = 6'($urandom_range(0, 63));
          end
          #1;
          acc = s3_valid && s3_ready;
          if (acc) begin
            r_beat_t b;
            b.resp = s3_resp; b.last = s3_last; b.user = s3_user; b.data = s3_data; b.id = s3_id;
            sb3.push_back(b);
            sent++;
          end
        end
        @(negedge clk);
        s3_valid = 1'b0;
        check("rand_sent", sent, 1000);
      end
      begin : mon3
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          m3_ready = ($urandom_range(0, 2) != 0);
          #1;
          if (m3_valid && m3_ready) begin
            if (sb3.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL rand_underflow: got beat %0h expected none", m3_data);
            end else begin
              check("rand_beat", {m3_resp, m3_last, m3_user, m3_data, m3_id}, sb3.pop_front());
            end
            got++;
          end
        end
        @(negedge clk);
        m3_ready = 1'b0;
        check("rand_received", got, 1000);
      end
    join
    check("rand_leftover", sb3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
